// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, constants and accumulator state encoding.
package fp16_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;
  localparam int FP16_W = SIGN_W + EXP_W + MAN_W;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  // All-ones exponent marks Inf or NaN.
  function automatic logic is_exp_max(input logic [FP16_W-1:0] v);
    return &v[FP16_W-SIGN_W-1 -: EXP_W];
  endfunction

endpackage

// File: rtl/fp16_acc_counter.sv
// Beat counter for the accumulator; saturates at MAX_LEN and flags the beat that reaches it.
module fp16_acc_counter
  import fp16_pkg::*;
#(
  parameter int MAX_LEN = 256,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          hit_max_o
);

  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_LEN - 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign hit_max_o = inc_i && (count_q == LAST_BEAT);

endmodule

// File: rtl/fp16_accumulator.sv
// Streaming FP16 row-sum stage around an external combinational adder.
// Optional FP16_ACC_NAN_GUARD_EN forces a quiet NaN result when any beat was Inf/NaN.
module fp16_accumulator
  import fp16_pkg::*;
#(
  parameter int MAX_LEN = 256,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  input  logic          in_last,
  output logic [15:0]   add_a,
  output logic [15:0]   add_b,
  input  logic [15:0]   add_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [CW-1:0] out_count,
  output logic          out_len_err
);

  acc_state_t  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        err_q, err_d;
  logic        accept, hs_out, clr, hit_max;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign hs_out    = out_valid && out_ready;
  assign clr       = hs_out;

  // The adder sits outside; acc feeds operand a, the incoming beat feeds b directly.
  assign add_a = acc_q;
  assign add_b = in_data;

  fp16_acc_counter #(.MAX_LEN(MAX_LEN)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .inc_i    (accept),
    .count_o  (out_count),
    .hit_max_o(hit_max)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d = add_sum;
          if (in_last || hit_max) begin
            state_d = DONE;
            err_d   = hit_max && !in_last;
          end else begin
            state_d = ACC;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = FP16_ZERO;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= FP16_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  assign out_len_err = err_q;

`ifdef FP16_ACC_NAN_GUARD_EN
  logic nan_q, nan_d;

  always_comb begin
    nan_d = nan_q;
    if (hs_out) begin
      nan_d = 1'b0;
    end else if (accept && is_exp_max(in_data)) begin
      nan_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nan_q <= 1'b0;
    end else begin
      nan_q <= nan_d;
    end
  end

  assign out_data = (out_valid && nan_q) ? FP16_QNAN : acc_q;
`else
  assign out_data = acc_q;
`endif

endmodule

// File: doc/fp16_accumulator.md
# fp16_accumulator

Streaming FP16 reduction stage for the NPU datapath. Accepts a valid/ready stream of FP16 values, folds each beat into a running sum through the external combinational FP16 adder, and emits one registered result per vector on `in_last`. It is the sequential stage that feeds the adder's `a`/`b` inputs and consumes its `result`. It turns the stateless adder into a dot-product/row-sum accumulator.

## Interface
Parameters:
- `MAX_LEN`, default 256: maximum beats per vector. `CW = $clog2(MAX_LEN+1)`.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: stage can accept a beat.
- `in_data`, input, 16: FP16 operand (1/5/10).
- `in_last`, input, 1: final beat of the vector.
- `add_a`, output, 16: adder operand a; always equals the `acc` register.
- `add_b`, output, 16: adder operand b; equals `in_data` combinationally.
- `add_sum`, input, 16: adder result, combinational from `add_a`/`add_b`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts result.
- `out_data`, output, 16: accumulated FP16 sum.
- `out_count`, output, CW: beats folded into `out_data`.
- `out_len_err`, output, 1: vector hit MAX_LEN without `in_last`.

## Operation
- State machine with three states: IDLE (acc=0, count=0), ACC (mid-vector), DONE (result held).
- `in_ready = (state != DONE)`.
- Beat accepted when `in_valid && in_ready`. On acceptance: `acc <= add_sum`, `count <= count+1`.
- The first beat uses acc=16'h0000, so the adder passes `in_data` through unchanged.
- IDLE→ACC: accepted beat with `in_last=0`.
- IDLE/ACC→DONE: accepted beat with `in_last=1`, or accepted beat that makes `count==MAX_LEN`. In the MAX_LEN case `out_len_err <= 1`.
- In DONE: `out_valid=1`, `out_data=acc`, `out_count=count`.
- DONE→IDLE when `out_ready`. This clears acc, count and `out_len_err`.
- Beats arriving after a MAX_LEN cut start a new vector. Their `in_last` is honoured normally.
- No internal arithmetic. All FP16 math is done by the adder, including flush-to-zero on underflow and exact cancellation to zero.
- `count` saturates logically at MAX_LEN and never wraps.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_count=0`, `out_len_err=0`, `acc=0`, state IDLE.
- Throughput: one beat per cycle while in IDLE/ACC.
- Latency: the last beat is accepted on edge N; `out_valid` is high from N+1. No bubbles are inserted before the last beat.
- `out_data` and `out_count` are stable while `out_valid && !out_ready`.
- Minimum vector-to-vector gap is one cycle (the DONE cycle with `out_ready=1`). `in_ready` returns high the cycle after the handshake.
- A single-beat vector (`in_last` on the first beat) produces `out_data=in_data`, `out_count=1`.
- `rst` asserted mid-vector or in DONE takes effect on the next edge. The partial sum is discarded and no output is produced.
- The combinational path `in_data`→adder→`acc` D-input is the critical path. No register is inserted on it.

## Configuration
- Macro: `FP16_ACC_NAN_GUARD_EN`.
- Defined:
  - An accepted beat with exponent 5'h1F (Inf/NaN) sets a sticky flag for the vector.
  - When the flag is set, `out_data` in DONE is forced to 16'h7E00.
  - The flag clears with acc on the output handshake or on reset.
- Undefined: no flag. Exponent-31 inputs pass to the adder unmodified.

## Structure
- Shared package `fp16_pkg`:
  - FP16 field widths (SIGN_W=1, EXP_W=5, MAN_W=10).
  - Constants `FP16_ZERO=16'h0000` and `FP16_QNAN=16'h7E00`.
  - State enum `acc_state_t {IDLE, ACC, DONE}`.
- The adder stays outside this block, connected through the `add_*` ports.
- One sub-module is natural: `fp16_acc_counter`, the CW-bit beat counter with a `hit_max` output.

## Test plan
- 16'h3C00, 16'h4000 (last) → out_valid one cycle after last; out_data=16'h4200, out_count=2.
- Single beat 16'h3800 with last → out_data=16'h3800, out_count=1, out_len_err=0.
- 16'h4000, 16'hC000 (last) → out_data=16'h0000. Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0 throughout.
- MAX_LEN=4, five beats of 16'h3C00 with no last → result 16'h4400, count 4, out_len_err=1. The fifth beat is stalled until the handshake, then starts a new vector.
- `rst` pulsed after 2 of 3 beats → all outputs return to reset values. The next 16'h3C00 (last) vector yields 16'h3C00.
- With FP16_ACC_NAN_GUARD_EN: 16'h3C00, 16'h7C00, 16'h3C00 (last) → out_data=16'h7E00.
